// File: rtl/tile_overlay_if.sv
// vga_if: VGA timing bundle passed between the pipeline stages.
//   hcount, vcount : 11-bit pixel position
//   hsync, vsync   : sync pulses
//   hblnk, vblnk   : blanking flags
//   rgb            : 12-bit colour
// Modport "in" is for the upstream side of a stage and "out" for the downstream side.
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/tile_overlay.sv
// tile_overlay: draws up to N_OBJ rectangular, tile-textured objects onto the
// VGA stream. Objects come from a runtime-written descriptor table that is
// double-buffered. The shadow copy is written through the cfg port. The active
// copy is loaded from the shadow at a vblnk rising edge, after a commit.
// The stage drives a synchronous tile ROM and adds a fixed 3-cycle latency.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   enable           0 = pure pass-through (still delayed by 3 cycles)
//   cfg_valid/ready  descriptor write handshake
//   cfg_idx, cfg_*   descriptor index and fields
//   cfg_commit       request a shadow->active swap at the next vblnk rise
//   cfg_pending      commit requested, swap not yet done
//   rgb_pixel        tile ROM data (one cycle after pixel_addr)
//   pixel_addr       tile ROM address {row, col}
//   in / out         vga_if timing and colour, input and output
module tile_overlay #(
   parameter int          N_OBJ       = 8,
   parameter int          TILE_W_LOG2 = 5,
   parameter int          TILE_H_LOG2 = 5,
   parameter logic [11:0] KEY_RGB     = 12'hF0F,
   parameter logic [11:0] BLANK_RGB   = 12'h888,
   localparam int         IDX_W       = (N_OBJ > 1) ? $clog2(N_OBJ) : 1,
   localparam int         AW          = TILE_H_LOG2 + TILE_W_LOG2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [IDX_W-1:0]       cfg_idx,
   input  logic                   cfg_en,
   input  logic [10:0]            cfg_hstart,
   input  logic [10:0]            cfg_vstart,
   input  logic [10:0]            cfg_width,
   input  logic [10:0]            cfg_height,
   input  logic [TILE_W_LOG2-1:0] cfg_xoff,
   input  logic                   cfg_commit,
   output logic                   cfg_pending,
   input  logic [11:0]            rgb_pixel,
   output logic [AW-1:0]          pixel_addr,
   vga_if.in                      in,
   vga_if.out                     out
);

   typedef struct packed {
      logic                   en;
      logic [10:0]            hstart;
      logic [10:0]            vstart;
      logic [10:0]            width;
      logic [10:0]            height;
      logic [TILE_W_LOG2-1:0] xoff;
   } desc_t;

   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
      logic [11:0] rgb;
   } vga_t;

   localparam logic [IDX_W:0] N_OBJ_L = (IDX_W+1)'(N_OBJ);

   desc_t r_shadow [N_OBJ];
   desc_t r_active [N_OBJ];

   logic r_prev_vblnk;
   logic r_cfg_pending;
   logic r_cfg_ready;

   logic w_vblnk_rise;
   logic w_swap;
   logic w_pending_nxt;
   logic w_cfg_fire;

   logic                   w_hit;
   logic [TILE_H_LOG2-1:0] w_row;
   logic [TILE_W_LOG2-1:0] w_col;

   vga_t          r_s1, r_s2;
   logic          r_hit1, r_hit2;
   logic [AW-1:0] r_pixel_addr;

   assign cfg_ready   = r_cfg_ready;
   assign cfg_pending = r_cfg_pending;
   assign pixel_addr  = r_pixel_addr;

   // Handshake: a descriptor write is taken on any edge where cfg_valid and
   // cfg_ready are both high. cfg_ready is low for as long as a commit is
   // pending, so the shadow table stays frozen until the swap has copied it.
   assign w_cfg_fire    = cfg_valid & r_cfg_ready;
   assign w_vblnk_rise  = in.vblnk & ~r_prev_vblnk;
   assign w_swap        = r_cfg_pending & w_vblnk_rise;
   // A commit that arrives on the rising edge itself only sets pending. The
   // swap therefore waits for the next frame and never tears this one.
   assign w_pending_nxt = w_swap ? 1'b0 :
                          (cfg_commit & ~r_cfg_pending) ? 1'b1 : r_cfg_pending;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev_vblnk  <= 1'b0;
         r_cfg_pending <= 1'b0;
         r_cfg_ready   <= 1'b0;
         for (int i = 0; i < N_OBJ; i++) begin
            r_shadow[i] <= '0;
            r_active[i] <= '0;
         end
      end else begin
         r_prev_vblnk  <= in.vblnk;
         r_cfg_pending <= w_pending_nxt;
         r_cfg_ready   <= ~w_pending_nxt;
         if (w_swap) begin
            for (int i = 0; i < N_OBJ; i++) r_active[i] <= r_shadow[i];
         end
         // Indices past the table are accepted but dropped.
         if (w_cfg_fire && ({1'b0, cfg_idx} < N_OBJ_L)) begin
            r_shadow[cfg_idx] <= '{cfg_en, cfg_hstart, cfg_vstart,
                                   cfg_width, cfg_height, cfg_xoff};
         end
      end
   end

   // Hit test. The loop scans downwards, so the lowest index is written last
   // and wins. Bounds are summed at 12 bits, so an object at the right or
   // bottom edge of the screen does not wrap back to zero.
   always_comb begin
      w_hit = 1'b0;
      w_row = '0;
      w_col = '0;
      for (int i = N_OBJ - 1; i >= 0; i--) begin
         if (r_active[i].en &&
             ({1'b0, in.vcount} >= {1'b0, r_active[i].vstart}) &&
             ({1'b0, in.vcount} < ({1'b0, r_active[i].vstart} + {1'b0, r_active[i].height})) &&
             ({1'b0, in.hcount} >= {1'b0, r_active[i].hstart}) &&
             ({1'b0, in.hcount} < ({1'b0, r_active[i].hstart} + {1'b0, r_active[i].width}))) begin
            w_hit = 1'b1;
            // Truncation to the tile size makes the texture repeat.
            w_row = TILE_H_LOG2'(in.vcount - r_active[i].vstart);
            w_col = TILE_W_LOG2'(in.hcount - r_active[i].hstart + 11'(r_active[i].xoff));
         end
      end
   end

   // Pipeline: stage 1 registers the ROM address, stage 2 waits for the ROM,
   // and stage 3 selects the colour.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pixel_addr <= '0;
         r_hit1       <= 1'b0;
         r_hit2       <= 1'b0;
         r_s1         <= '0;
         r_s2         <= '0;
         out.hcount   <= '0;
         out.vcount   <= '0;
         out.hsync    <= 1'b0;
         out.vsync    <= 1'b0;
         out.hblnk    <= 1'b0;
         out.vblnk    <= 1'b0;
         out.rgb      <= '0;
      end else begin
         if (w_hit) r_pixel_addr <= {w_row, w_col};
         r_hit1 <= w_hit & enable;
         r_s1   <= {in.hcount, in.vcount, in.hsync, in.vsync, in.hblnk, in.vblnk, in.rgb};
         r_hit2 <= r_hit1;
         r_s2   <= r_s1;

         out.hcount <= r_s2.hcount;
         out.vcount <= r_s2.vcount;
         out.hsync  <= r_s2.hsync;
         out.vsync  <= r_s2.vsync;
         out.hblnk  <= r_s2.hblnk;
         out.vblnk  <= r_s2.vblnk;
         if (r_s2.hblnk | r_s2.vblnk)
            out.rgb <= BLANK_RGB;
         else if (!r_hit2 || (rgb_pixel == KEY_RGB))
            out.rgb <= r_s2.rgb;
         else
            out.rgb <= rgb_pixel;
      end
   end

endmodule

// File: tb/tb_tile_overlay.sv
// Testbench for tile_overlay: table-driven address vectors, hand-written
// multi-cycle sequences, and randomized traffic checked against a frame-level
// reference model of the descriptor tables and colour rules.
module tb_tile_overlay;

   localparam int N    = 6;
   localparam int IW   = 3;
   localparam int OUTW = 38;
   localparam logic [11:0] KEY   = 12'hF0F;
   localparam logic [11:0] BLANK = 12'h888;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [IW-1:0] cfg_idx;
   logic        cfg_en;
   logic [10:0] cfg_hstart, cfg_vstart, cfg_width, cfg_height;
   logic [4:0]  cfg_xoff;
   logic        cfg_commit;
   logic        cfg_pending;
   logic [11:0] rgb_pixel;
   logic [9:0]  pixel_addr;

   vga_if vin ();
   vga_if vout ();

   tile_overlay #(.N_OBJ(N)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
      .cfg_en(cfg_en), .cfg_hstart(cfg_hstart), .cfg_vstart(cfg_vstart),
      .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_xoff(cfg_xoff),
      .cfg_commit(cfg_commit), .cfg_pending(cfg_pending),
      .rgb_pixel(rgb_pixel), .pixel_addr(pixel_addr),
      .in(vin), .out(vout)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- tile ROM ----------------
   // Column 7 holds the key colour, column 8 holds green, and every other
   // texel is derived from its address (its low bits are 01, so it never equals the key).
   function automatic logic [11:0] rom_f(input logic [9:0] a);
      if (a[4:0] == 5'd7) return KEY;
      if (a[4:0] == 5'd8) return 12'h0A0;
      return {a ^ 10'h2A5, 2'b01};
   endfunction

   always @(posedge clk) rgb_pixel <= rom_f(pixel_addr);

   // ---------------- reference model ----------------
   typedef struct { bit en; int hs, vs, w, h, xo; } mdesc_t;
   mdesc_t m_shadow [N];
   mdesc_t m_active [N];
   bit         m_pending, m_ready, m_prev_vblnk;
   logic [9:0] m_addr;
   logic [OUTW-1:0] exp_q [$];

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [OUTW-1:0] out_bus();
      return {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb};
   endfunction

   // One clock: predict from the current inputs, step the edge, update model, check.
   task automatic tick();
      bit hit, fire, rise, swap;
      int hc, vc, a;
      logic [11:0] erg, rom;
      logic [OUTW-1:0] e;
      if (rst) begin
         @(posedge clk);
         for (int i = 0; i < N; i++) begin
            m_shadow[i] = '{default: 0};
            m_active[i] = '{default: 0};
         end
         m_pending = 0; m_ready = 0; m_prev_vblnk = 0; m_addr = '0;
         exp_q.delete();
         exp_q.push_back('0);
         exp_q.push_back('0);
         #1;
         chk("rst_out", 64'(out_bus()), 64'd0);
         chk("rst_addr", 64'(pixel_addr), 64'd0);
         chk("rst_pending", 64'(cfg_pending), 64'd0);
         chk("rst_ready", 64'(cfg_ready), 64'd0);
         return;
      end
      hc = int'(vin.hcount);
      vc = int'(vin.vcount);
      hit = 0; a = 0;
      for (int i = N - 1; i >= 0; i--) begin
         if (m_active[i].en &&
             vc >= m_active[i].vs && vc < m_active[i].vs + m_active[i].h &&
             hc >= m_active[i].hs && hc < m_active[i].hs + m_active[i].w) begin
            hit = 1;
            a = ((vc - m_active[i].vs) % 32) * 32 + ((hc - m_active[i].hs + m_active[i].xo) % 32);
         end
      end
      if (vin.hblnk || vin.vblnk) erg = BLANK;
      else if (!(hit && enable)) erg = vin.rgb;
      else begin
         rom = rom_f(10'(a));
         erg = (rom == KEY) ? vin.rgb : rom;
      end
      e = {vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk, erg};
      fire = cfg_valid && m_ready;
      rise = vin.vblnk && !m_prev_vblnk;
      swap = m_pending && rise;

      @(posedge clk);
      exp_q.push_back(e);
      if (hit) m_addr = 10'(a);
      if (swap) m_active = m_shadow;
      if (fire && int'(cfg_idx) < N) begin
         m_shadow[cfg_idx].en = cfg_en;
         m_shadow[cfg_idx].hs = int'(cfg_hstart);
         m_shadow[cfg_idx].vs = int'(cfg_vstart);
         m_shadow[cfg_idx].w  = int'(cfg_width);
         m_shadow[cfg_idx].h  = int'(cfg_height);
         m_shadow[cfg_idx].xo = int'(cfg_xoff);
      end
      if (swap) m_pending = 0;
      else if (cfg_commit && !m_pending) m_pending = 1;
      m_ready = !m_pending;
      m_prev_vblnk = vin.vblnk;

      #1;
      if (exp_q.size() == 3) chk("out_bus", 64'(out_bus()), 64'(exp_q.pop_front()));
      chk("pixel_addr", 64'(pixel_addr), 64'(m_addr));
      chk("cfg_pending", 64'(cfg_pending), 64'(m_pending));
      chk("cfg_ready", 64'(cfg_ready), 64'(m_ready));
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_pix(input int h, input int v, input logic [11:0] rgb);
      vin.hcount = 11'(h); vin.vcount = 11'(v); vin.rgb = rgb;
      vin.hblnk = 1'b0; vin.vblnk = 1'b0;
      vin.hsync = 1'b0; vin.vsync = 1'b0;
   endtask

   task automatic cfg_write(input int idx, input bit en, input int hs, input int vs,
                            input int w, input int h, input int xo, input bit commit);
      cfg_valid = 1'b1; cfg_idx = IW'(idx); cfg_en = en;
      cfg_hstart = 11'(hs); cfg_vstart = 11'(vs);
      cfg_width = 11'(w); cfg_height = 11'(h); cfg_xoff = 5'(xo);
      cfg_commit = commit;
      tick();
      cfg_valid = 1'b0; cfg_commit = 1'b0;
   endtask

   task automatic do_commit();
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
   endtask

   task automatic frame();
      vin.vblnk = 1'b1;
      tick();
      vin.vblnk = 1'b0;
      tick();
   endtask

   // Drive one pixel, two filler pixels, then check that pixel's output colour.
   task automatic probe(input string name, input int h, input int v,
                        input logic [11:0] rgb, input logic [11:0] exp_rgb);
      set_pix(h, v, rgb);
      tick();
      set_pix(0, 2000, 12'h000);
      tick();
      tick();
      chk(name, 64'(vout.rgb), 64'(exp_rgb));
   endtask

   // ---------------- address vectors ----------------
   typedef struct { int h; int v; logic [9:0] exp_addr; } avec_t;
   avec_t avec [10];

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // idx0 {320,704,32x33,xoff 0}; idx2 {100,0,64x32,xoff 16}
      avec[0] = '{330, 710, 10'd202};   // row 6, col 10
      avec[1] = '{352, 710, 10'd202};   // right of object: hold
      avec[2] = '{351, 736, 10'd31};    // row 32 wraps to 0, col 31
      avec[3] = '{319, 710, 10'd31};    // left of object: hold
      avec[4] = '{100, 5,   10'd176};   // col 0+16 = 16
      avec[5] = '{116, 5,   10'd160};   // col 32 wraps to 0
      avec[6] = '{163, 31,  10'd1007};  // row 31, col 79 mod 32 = 15
      avec[7] = '{164, 31,  10'd1007};  // past width: hold
      avec[8] = '{320, 737, 10'd1007};  // below height 33: hold
      avec[9] = '{320, 704, 10'd0};     // top-left corner

      rst = 1'b1; enable = 1'b1;
      cfg_valid = 0; cfg_idx = '0; cfg_en = 0; cfg_hstart = '0; cfg_vstart = '0;
      cfg_width = '0; cfg_height = '0; cfg_xoff = '0; cfg_commit = 0;
      set_pix(0, 0, 12'h000);
      for (int i = 0; i < 3; i++) tick();
      rst = 1'b0;

      // Pass-through with empty tables, including blanking.
      for (int i = 0; i < 40; i++) begin
         set_pix($urandom_range(0, 800), $urandom_range(0, 700), 12'($urandom));
         vin.hblnk = ($urandom_range(0, 3) == 0);
         tick();
      end
      set_pix(10, 10, 12'h000);
      probe("empty_pass", 330, 710, 12'h3C5, 12'h3C5);

      // Write two descriptors; the second write rides with the commit.
      cfg_write(0, 1, 320, 704, 32, 33, 0, 0);
      cfg_write(2, 1, 100, 0, 64, 32, 16, 1);
      chk("pending_set", 64'(cfg_pending), 64'd1);
      chk("ready_low_pending", 64'(cfg_ready), 64'd0);
      cfg_write(3, 1, 500, 500, 20, 20, 0, 0);  // refused: ready is low
      probe("no_swap_yet", 330, 710, 12'h111, 12'h111);
      vin.vblnk = 1'b1;
      tick();
      chk("pending_clear_at_vblnk", 64'(cfg_pending), 64'd0);
      vin.vblnk = 1'b0;
      tick();

      for (int i = 0; i < 10; i++) begin
         set_pix(avec[i].h, avec[i].v, 12'($urandom));
         tick();
         chk("addr_vec", 64'(pixel_addr), 64'(avec[i].exp_addr));
      end

      probe("texel", 330, 710, 12'h123, 12'h9BD);
      probe("key_transparent", 327, 704, 12'h123, 12'h123);
      probe("green_texel", 328, 704, 12'h456, 12'h0A0);
      probe("right_edge_pass", 352, 710, 12'h789, 12'h789);
      probe("refused_write", 510, 510, 12'h5A5, 12'h5A5);
      enable = 1'b0;
      probe("disabled_pass", 330, 710, 12'hABC, 12'hABC);
      enable = 1'b1;

      // Overlap: idx0 wins until it is disabled and swapped out.
      cfg_write(0, 1, 400, 400, 16, 16, 0, 0);
      cfg_write(1, 1, 390, 390, 32, 32, 3, 1);
      frame();
      set_pix(405, 402, 12'h0F0); tick();
      chk("overlap_idx0", 64'(pixel_addr), 64'd69);
      cfg_write(0, 0, 400, 400, 16, 16, 0, 1);
      set_pix(406, 402, 12'h0F0); tick();
      chk("overlap_before_swap", 64'(pixel_addr), 64'd70);
      frame();
      set_pix(406, 402, 12'h0F0); tick();
      chk("overlap_idx1", 64'(pixel_addr), 64'd403);

      // Commit on the vblnk rising edge waits a whole frame.
      cfg_write(4, 1, 600, 600, 10, 10, 0, 0);
      set_pix(0, 2000, 12'h000);
      vin.vblnk = 1'b1; cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      chk("commit_at_rise", 64'(cfg_pending), 64'd1);
      tick();
      vin.vblnk = 1'b0;
      tick();
      chk("no_swap_same_frame", 64'(cfg_pending), 64'd1);
      probe("late_swap_pass", 605, 605, 12'h246, 12'h246);
      vin.vblnk = 1'b1;
      tick();
      chk("swap_next_frame", 64'(cfg_pending), 64'd0);
      vin.vblnk = 1'b0;
      tick();

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 1) == 0)
            set_pix($urandom_range(0, 700), $urandom_range(0, 700), 12'($urandom));
         else
            set_pix($urandom_range(0, 2047), $urandom_range(0, 2047), 12'($urandom));
         vin.hsync = 1'($urandom);
         vin.vsync = 1'($urandom);
         vin.hblnk = ($urandom_range(0, 7) == 0);
         vin.vblnk = (i % 200) >= 190;
         enable = ($urandom_range(0, 15) != 0);
         cfg_valid = ($urandom_range(0, 3) == 0);
         cfg_idx = IW'($urandom_range(0, 7));
         cfg_en = ($urandom_range(0, 3) != 0);
         cfg_hstart = 11'(($urandom_range(0, 7) == 0) ? $urandom_range(1900, 2047) : $urandom_range(0, 600));
         cfg_vstart = 11'($urandom_range(0, 600));
         cfg_width = 11'($urandom_range(0, 400));
         cfg_height = 11'($urandom_range(0, 400));
         cfg_xoff = 5'($urandom);
         cfg_commit = ($urandom_range(0, 31) == 0);
         tick();
      end
      cfg_valid = 0; cfg_commit = 0; enable = 1;
      set_pix(0, 2000, 12'h000);
      tick();
      frame();

      // Reset mid-line clears the tables.
      cfg_write(0, 1, 100, 0, 64, 32, 16, 1);
      frame();
      set_pix(110, 5, 12'h321); tick();
      chk("pre_reset_addr", 64'(pixel_addr), 64'd186);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      probe("post_reset_pass", 110, 5, 12'h5A5, 12'h5A5);
      chk("post_reset_addr", 64'(pixel_addr), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/tile_overlay.md
Name: tile_overlay

Overview:
- Parametrised successor of the fixed-map ladder overlay.
- Draws up to N_OBJ rectangular, tile-textured objects (ladders, decorations, platforms) onto the VGA stream.
- Object placement comes from a descriptor table that is written at runtime, not from fixed package constants; colour-key transparency is supported.
- Sits in the vga_if pipeline between the background stage and the sprite stages, and drives a synchronous tile ROM.

Parameters:
- N_OBJ, 8, number of object descriptors; min 1, max 16.
- TILE_W_LOG2, 5, log2 of tile width in pixels.
- TILE_H_LOG2, 5, log2 of tile height in pixels.
- KEY_RGB, 12'hF0F, tile texel colour treated as transparent.
- BLANK_RGB, 12'h888, colour driven during hblnk/vblnk.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  overlay enable (game started); 0 = pass-through.
- cfg_valid  in  1  descriptor write request.
- cfg_ready  out  1  descriptor write accepted when cfg_valid & cfg_ready.
- cfg_idx  in  $clog2(N_OBJ) (min 1)  descriptor index.
- cfg_en  in  1  descriptor enable.
- cfg_hstart  in  11  left edge x.
- cfg_vstart  in  11  top edge y.
- cfg_width  in  11  width in pixels; 0 = never hits.
- cfg_height  in  11  height in pixels; 0 = never hits.
- cfg_xoff  in  TILE_W_LOG2  texture column offset (ramp alignment).
- cfg_commit  in  1  request shadow-to-active table swap.
- cfg_pending  out  1  commit requested, swap not yet done.
- rgb_pixel  in  12  tile ROM data, one cycle after the address.
- pixel_addr  out  TILE_H_LOG2+TILE_W_LOG2  tile ROM address {row, col}.
- in  vga_if.in  —  timing and rgb input.
- out  vga_if.out  —  timing and rgb output.

Behaviour:
- Descriptor tables:
  - Two tables: shadow (written via cfg) and active (used for drawing).
  - Write: on cfg_valid & cfg_ready, shadow[cfg_idx] <= {cfg_en, cfg_hstart, cfg_vstart, cfg_width, cfg_height, cfg_xoff}.
  - cfg_idx >= N_OBJ: the write is accepted and discarded.
- cfg_ready and commit:
  - cfg_ready = ~cfg_pending, registered; 0 during reset.
  - cfg_commit with cfg_pending=0 sets cfg_pending. A write accepted in the same cycle as the commit is included in it.
  - cfg_commit while cfg_pending=1 is ignored.
- Swap:
  - Occurs at the vblnk rising edge: in.vblnk=1 while the registered previous vblnk=0.
  - If cfg_pending=1 at that edge: active <= shadow (whole table in one cycle), cfg_pending <= 0.
  - A commit that arrives in the same cycle as the vblnk rising edge swaps at the next frame's rising edge. No mid-frame tearing.
- Hit test (stage 1, from in.* of the current cycle):
  - Entry i hits when en_i and vstart_i <= vcount < vstart_i+height_i and hstart_i <= hcount < hstart_i+width_i.
  - Sums are computed at 12 bits, so there is no wrap at screen edges.
  - Lowest index wins.
- Address:
  - row = (vcount − vstart)[TILE_H_LOG2-1:0]
  - col = (hcount − hstart + xoff)[TILE_W_LOG2-1:0]
  - Both wrap modulo tile size, so the texture repeats.
  - On a hit, pixel_addr <= {row, col} at the next edge; otherwise pixel_addr holds its value.
- Pipeline:
  - Input sampled in cycle k → pixel_addr registered at edge k+1.
  - ROM presents rgb_pixel after edge k+2.
  - out.* registered at edge k+3.
  - Fixed 3-cycle latency on all out fields (hcount, vcount, syncs, blanks, rgb). Hit flag and in.rgb are delayed to match.
- Output colour, in priority order:
  1. Delayed hblnk|vblnk → BLANK_RGB.
  2. enable=0 or no hit → delayed in.rgb.
  3. rgb_pixel == KEY_RGB → delayed in.rgb.
  4. Otherwise rgb_pixel.
- enable is sampled with the stage-1 hit, so it takes effect on pixel boundaries.
- Reset:
  - Clears both tables (all en=0), cfg_pending, pixel_addr, all out.* fields, and the pipeline registers.
  - Reset mid-frame: output is pass-through until new descriptors are committed and swapped.

Test Plan:
1. Reset, enable=1, no descriptors → out.rgb equals in.rgb delayed 3 cycles; blanking → 12'h888; pixel_addr = 0.
2. Write idx0 {en=1, h=320, v=704, w=32, h=33, xoff=0}, commit, run to vblnk → cfg_pending falls at the vblnk rising edge. At (hcount=330, vcount=710), pixel_addr = {6, 10}; out.rgb = ROM texel 3 cycles after the input pixel. At hcount=352 → pass-through.
3. idx0 and idx1 overlapping at (400,400), both enabled → idx0's address is used; disabling idx0 via commit+swap → idx1's address is used from the next frame.
4. ROM returns 12'hF0F inside an object → out.rgb = in.rgb; ROM returns 12'h0A0 → out.rgb = 12'h0A0.
5. Commit mid-frame, then a write attempt → cfg_ready=0, the write is not accepted, the active table is unchanged until vblnk; commit coincident with the vblnk rising edge → swap occurs one frame later.
6. xoff=16, hstart=100, hcount=100 → col=16; hcount=116 → col=0 (wrap). Assert rst mid-line → all outputs 0 on the next edge and the table is cleared.
